// File: rtl/width_16to8_buf.sv
// Buffers 16-bit valid-only words in a small FIFO and re-serialises each word
// as two bytes on a valid/ready interface; words arriving while full are dropped.
module width_16to8_buf #(
   parameter int unsigned DEPTH      = 4,
   parameter bit          HIGH_FIRST = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         valid_in,
   input  logic [15:0]                  data_in,
   input  logic                         ready_out,
   output logic                         valid_out,
   output logic [7:0]                   data_out,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = $clog2(DEPTH+1);

   typedef enum logic [1:0] {EMPTY, BYTE0, BYTE1} state_t;

   state_t          state_q, state_d;
   logic [15:0]     mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic            overflow_q, overflow_d;
   logic            valid_q, valid_d;
   logic [7:0]      data_q, data_d, hold_q, hold_d;
   logic            xfer, pop, push, not_empty;
   logic [15:0]     head_w;
   logic [7:0]      first_b, second_b;

   assign xfer      = valid_q & ready_out;
   assign not_empty = (level_q != '0);
   assign head_w    = mem_q[rd_ptr_q];
   assign first_b   = HIGH_FIRST ? head_w[15:8] : head_w[7:0];
   assign second_b  = HIGH_FIRST ? head_w[7:0]  : head_w[15:8];

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state; pop is decided here since it coincides with entering BYTE0
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         EMPTY: begin
            if (not_empty) begin
               pop     = 1'b1;
               state_d = BYTE0;
            end
         end
         BYTE0: begin
            if (xfer) state_d = BYTE1;
         end
         BYTE1: begin
            if (xfer) begin
               if (not_empty) begin
                  pop     = 1'b1;
                  state_d = BYTE0;
               end else begin
                  state_d = EMPTY;
               end
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      hold_d  = hold_q;
      if (pop) begin
         valid_d = 1'b1;
         data_d  = first_b;
         hold_d  = second_b;
      end else if (state_q == BYTE0 && xfer) begin
         data_d  = hold_q;
      end else if (state_q == BYTE1 && xfer) begin
         valid_d = 1'b0;
      end
   end

   // FIFO bookkeeping; a pop frees the slot for a same-cycle push when full
   always_comb begin
      push       = valid_in & ((level_q != LW'(DEPTH)) | pop);
      wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d    = level_q;
      if (push && !pop) level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
      overflow_d = overflow_q | (valid_in & ~push);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         hold_q     <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         hold_q     <= hold_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && push) mem_q[wr_ptr_q] <= data_in;
   end

   assign valid_out = valid_q;
   assign data_out  = data_q;
   assign level     = level_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_width_16to8_buf.sv
// Self-checking bench: directed vector table, hand sequences for streaming and
// mid-word reset, then random traffic against a queue-based reference model.
module tb_width_16to8_buf;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned LW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst_n, valid_in, ready_out;
   logic [15:0]   data_in;
   logic          v_hi, o_hi, v_lo, o_lo;
   logic [7:0]    d_hi, d_lo;
   logic [LW-1:0] l_hi, l_lo;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   width_16to8_buf #(.DEPTH(DEPTH), .HIGH_FIRST(1'b1)) u_hi (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
      .ready_out(ready_out), .valid_out(v_hi), .data_out(d_hi),
      .level(l_hi), .overflow(o_hi));

   width_16to8_buf #(.DEPTH(DEPTH), .HIGH_FIRST(1'b0)) u_lo (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
      .ready_out(ready_out), .valid_out(v_lo), .data_out(d_lo),
      .level(l_lo), .overflow(o_lo));

   // Reference model: FIFO of words, the word being sent and bytes remaining
   logic [15:0] m_fifo[$];
   logic [15:0] m_word;
   int          m_rem = 0;
   bit          m_ovf = 1'b0;

   task automatic model_step(input bit rn, input bit vin, input logic [15:0] din, input bit rdy);
      int pre;
      bit pop, room;
      if (!rn) begin
         m_fifo.delete();
         m_rem = 0;
         m_ovf = 1'b0;
      end else begin
         pre = m_fifo.size();
         if (m_rem > 0 && rdy) m_rem--;
         pop  = (m_rem == 0) && (pre > 0);
         room = (pre < DEPTH) || pop;
         if (pop) begin
            m_word = m_fifo.pop_front();
            m_rem  = 2;
         end
         if (vin) begin
            if (room) m_fifo.push_back(din);
            else m_ovf = 1'b1;
         end
      end
   endtask

   function automatic logic [7:0] model_byte(input bit hf);
      bit hi_half;
      hi_half = hf ? (m_rem == 2) : (m_rem == 1);
      return hi_half ? m_word[15:8] : m_word[7:0];
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("model_valid_hi", 16'(v_hi), 16'(m_rem > 0));
      chk("model_valid_lo", 16'(v_lo), 16'(m_rem > 0));
      chk("model_level_hi", 16'(l_hi), 16'(m_fifo.size()));
      chk("model_level_lo", 16'(l_lo), 16'(m_fifo.size()));
      chk("model_ovf_hi",   16'(o_hi), 16'(m_ovf));
      chk("model_ovf_lo",   16'(o_lo), 16'(m_ovf));
      if (m_rem > 0) begin
         chk("model_data_hi", 16'(d_hi), 16'(model_byte(1'b1)));
         chk("model_data_lo", 16'(d_lo), 16'(model_byte(1'b0)));
      end
   endtask

   task automatic step(input bit rn, input bit vin, input logic [15:0] din, input bit rdy);
      rst_n     = rn;
      valid_in  = vin;
      data_in   = din;
      ready_out = rdy;
      @(posedge clk);
      model_step(rn, vin, din, rdy);
      #1;
      check_model();
   endtask

   typedef struct {
      bit          rn;
      bit          vin;
      logic [15:0] din;
      bit          rdy;
      bit          ev;
      logic [7:0]  ed;
      logic [7:0]  edl;
      int          el;
      bit          eo;
      bit          cd;
   } vec_t;

   vec_t tv[$];

   function automatic void addv(bit rn, bit vin, logic [15:0] din, bit rdy, bit ev,
                                logic [7:0] ed, logic [7:0] edl, int el, bit eo, bit cd);
      vec_t v;
      v = '{rn, vin, din, rdy, ev, ed, edl, el, eo, cd};
      tv.push_back(v);
   endfunction

   initial begin
      logic [7:0] got[$];
      int first_c, last_c;
      bit v;

      rst_n = 1'b0; valid_in = 1'b0; data_in = '0; ready_out = 1'b0;

      // Reset with busy inputs
      for (int i = 0; i < 3; i++) addv(0, 1, 16'hFFFF, 1, 0, 8'h00, 8'h00, 0, 0, 1);
      // Single word
      addv(1, 1, 16'hA55A, 1, 0, 8'h00, 8'h00, 1, 0, 0);
      addv(1, 0, 16'h0000, 1, 1, 8'hA5, 8'h5A, 0, 0, 1);
      addv(1, 0, 16'h0000, 1, 1, 8'h5A, 8'hA5, 0, 0, 1);
      addv(1, 0, 16'h0000, 1, 0, 8'h00, 8'h00, 0, 0, 0);
      // Backpressure
      addv(1, 1, 16'h1234, 0, 0, 8'h00, 8'h00, 1, 0, 0);
      for (int i = 0; i < 5; i++) addv(1, 0, 16'h0000, 0, 1, 8'h12, 8'h34, 0, 0, 1);
      addv(1, 0, 16'h0000, 1, 1, 8'h34, 8'h12, 0, 0, 1);
      addv(1, 0, 16'h0000, 1, 0, 8'h00, 8'h00, 0, 0, 0);
      // Overflow
      addv(1, 1, 16'h0101, 0, 0, 8'h00, 8'h00, 1, 0, 0);
      addv(1, 1, 16'h0202, 0, 1, 8'h01, 8'h01, 1, 0, 1);
      addv(1, 1, 16'h0303, 0, 1, 8'h01, 8'h01, 2, 0, 1);
      addv(1, 1, 16'h0404, 0, 1, 8'h01, 8'h01, 3, 0, 1);
      addv(1, 1, 16'h0505, 0, 1, 8'h01, 8'h01, 4, 0, 1);
      addv(1, 1, 16'h0606, 0, 1, 8'h01, 8'h01, 4, 1, 1);
      addv(1, 0, 16'h0000, 1, 1, 8'h01, 8'h01, 4, 1, 1);
      for (int w = 2; w <= 5; w++) begin
         addv(1, 0, 16'h0000, 1, 1, 8'(w), 8'(w), 5 - w, 1, 1);
         addv(1, 0, 16'h0000, 1, 1, 8'(w), 8'(w), 5 - w, 1, 1);
      end
      addv(1, 0, 16'h0000, 1, 0, 8'h00, 8'h00, 0, 1, 0);

      for (int i = 0; i < tv.size(); i++) begin
         step(tv[i].rn, tv[i].vin, tv[i].din, tv[i].rdy);
         chk($sformatf("vec%0d_valid", i), 16'(v_hi), 16'(tv[i].ev));
         chk($sformatf("vec%0d_level", i), 16'(l_hi), 16'(tv[i].el));
         chk($sformatf("vec%0d_ovf", i),   16'(o_hi), 16'(tv[i].eo));
         if (tv[i].cd) begin
            chk($sformatf("vec%0d_data_hi", i), 16'(d_hi), 16'(tv[i].ed));
            chk($sformatf("vec%0d_data_lo", i), 16'(d_lo), 16'(tv[i].edl));
         end
      end

      // Streaming at the upstream peak rate
      step(0, 0, 16'h0000, 1);
      got.delete();
      first_c = -1;
      last_c  = -1;
      for (int c = 0; c < 20; c++) begin
         v = (c % 2 == 0) && (c / 2 < 8);
         step(1, v, v ? {8'(2 * (c / 2)), 8'(2 * (c / 2) + 1)} : 16'h0000, 1);
         chk("stream_level_le1", 16'(l_hi <= 1), 16'd1);
         chk("stream_ovf", 16'(o_hi), 16'd0);
         if (v_hi) begin
            got.push_back(d_hi);
            if (first_c < 0) first_c = c;
            last_c = c;
         end
      end
      chk("stream_count", 16'(got.size()), 16'd16);
      chk("stream_contiguous", 16'(last_c - first_c + 1), 16'd16);
      for (int j = 0; j < got.size(); j++) chk($sformatf("stream_byte%0d", j), 16'(got[j]), 16'(j));

      // Reset mid-word
      step(0, 0, 16'h0000, 0);
      step(1, 1, 16'h1111, 0);
      step(1, 1, 16'h2222, 0);
      step(1, 1, 16'h3333, 0);
      step(1, 0, 16'h0000, 1);
      step(0, 0, 16'h0000, 0);
      chk("midrst_valid", 16'(v_hi), 16'd0);
      chk("midrst_data",  16'(d_hi), 16'd0);
      chk("midrst_level", 16'(l_hi), 16'd0);
      chk("midrst_ovf",   16'(o_hi), 16'd0);
      got.delete();
      step(1, 1, 16'hBEEF, 1);
      if (v_hi) got.push_back(d_hi);
      for (int c = 0; c < 6; c++) begin
         step(1, 0, 16'h0000, 1);
         if (v_hi) got.push_back(d_hi);
      end
      chk("midrst_count", 16'(got.size()), 16'd2);
      if (got.size() >= 2) begin
         chk("midrst_byte0", 16'(got[0]), 16'h00BE);
         chk("midrst_byte1", 16'(got[1]), 16'h00EF);
      end

      // Random traffic, ready probability rising from 1/4 to always
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 199) != 0, 1'($urandom_range(0, 1)), 16'($urandom),
              $urandom_range(0, 3) < (i / 750) + 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
